// File: rtl/bip_pkg.sv
// bip_pkg: definitions shared by the BIP blocks.
//   - Opcode encodings, also used by bip_control. HALT is all-zero, so a zero word fetches as HALT.
//   - Default frame start marker for the program loader.
//   - Program loader state encoding.
package bip_pkg;

    localparam logic [4:0] OP_HALT                = 5'd0;
    localparam logic [4:0] OP_STORE               = 5'd1;
    localparam logic [4:0] OP_LOAD                = 5'd2;
    localparam logic [4:0] OP_LOAD_IMMEDIATE      = 5'd3;
    localparam logic [4:0] OP_ADD                 = 5'd4;
    localparam logic [4:0] OP_ADD_IMMEDIATE       = 5'd5;
    localparam logic [4:0] OP_SUBSTRACT           = 5'd6;
    localparam logic [4:0] OP_SUBSTRACT_IMMEDIATE = 5'd7;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StDataLo,
        StDataHi,
        StChk,
        StDone,
        StError
    } loader_state_e;

endpackage

// File: rtl/bip_program_loader_if.sv
// bip_program_loader_if: byte-stream input, instruction fetch port and loader status.
//   master: the stream source / fetching CPU side (drives i_* signals).
//   slave : the program loader (drives o_* signals).
//   i_rx_data/i_rx_valid  stream byte and its one-cycle strobe
//   i_addr_instr          fetch address
//   o_instruction         fetched word
//   o_cpu_reset           CPU held in reset while no valid image is present
//   o_load_done           image loaded and accepted
//   o_load_error          frame rejected (sticky until reset)
//   o_word_count          words written so far
interface bip_program_loader_if #(
    parameter int unsigned NB_DATA            = 16,
    parameter int unsigned NB_BYTE            = 8,
    parameter int unsigned LOG2_N_INSMEM_ADDR = 11
);
    logic [NB_BYTE-1:0]            i_rx_data;
    logic                          i_rx_valid;
    logic [LOG2_N_INSMEM_ADDR-1:0] i_addr_instr;
    logic [NB_DATA-1:0]            o_instruction;
    logic                          o_cpu_reset;
    logic                          o_load_done;
    logic                          o_load_error;
    logic [LOG2_N_INSMEM_ADDR:0]   o_word_count;

    modport master (
        output i_rx_data, i_rx_valid, i_addr_instr,
        input  o_instruction, o_cpu_reset, o_load_done, o_load_error, o_word_count
    );

    modport slave (
        input  i_rx_data, i_rx_valid, i_addr_instr,
        output o_instruction, o_cpu_reset, o_load_done, o_load_error, o_word_count
    );
endinterface

// File: rtl/bip_insmem.sv
// bip_insmem: instruction memory, one write port and one registered read port.
//   i_clock    clock
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write word
//   i_rd_addr  read address
//   o_rd_data  word at i_rd_addr, one cycle later
// No reset on the array or read register so it maps onto block RAM.
module bip_insmem #(
    parameter int unsigned NB_DATA            = 16,
    parameter int unsigned N_INSMEM_ADDR      = 2048,
    parameter int unsigned LOG2_N_INSMEM_ADDR = 11
) (
    input  logic                          i_clock,
    input  logic                          i_wr_en,
    input  logic [LOG2_N_INSMEM_ADDR-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0]            i_wr_data,
    input  logic [LOG2_N_INSMEM_ADDR-1:0] i_rd_addr,
    output logic [NB_DATA-1:0]            o_rd_data
);
    logic [NB_DATA-1:0] r_mem [N_INSMEM_ADDR];
    logic [NB_DATA-1:0] r_rd_data;

    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/bip_program_loader.sv
// bip_program_loader: receives a program image as a byte stream, writes it to instruction
// memory and serves instruction fetches once the image is complete.
//   i_clock, i_reset  clock and synchronous active-high reset
//   io_ldr            bip_program_loader_if.slave: stream in, fetch port, status out
// Frame: SYNC, LEN_LO, LEN_HI, then LEN words, low byte first.
// Optional feature macro BIP_LOADER_CHECKSUM_EN: a trailing byte equal to the XOR of all
// bytes after SYNC must follow the last word, otherwise the frame is rejected.
module bip_program_loader
    import bip_pkg::*;
#(
    parameter int unsigned NB_DATA            = 16,
    parameter int unsigned NB_BYTE            = 8,
    parameter int unsigned N_INSMEM_ADDR      = 2048,
    parameter int unsigned LOG2_N_INSMEM_ADDR = 11,
    parameter logic [7:0]  SYNC_BYTE          = SYNC_BYTE_DEFAULT
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    bip_program_loader_if.slave  io_ldr
);
    localparam int unsigned NB_CNT = LOG2_N_INSMEM_ADDR + 1;

    loader_state_e      r_state, w_state_next;
    logic [NB_CNT-1:0]  r_len;
    logic [NB_CNT-1:0]  r_wr_ptr;
    logic [NB_BYTE-1:0] r_lo;
    logic               r_fetch_ok;
    logic [NB_CNT-1:0]  w_len_rx;
    logic               w_last;
    logic               w_wr_en;
    logic [NB_DATA-1:0] w_rd_data;

    // Bits of the length field above the word-count width are dropped.
    assign w_len_rx = NB_CNT'({io_ldr.i_rx_data, r_lo});
    assign w_last   = (r_wr_ptr == r_len - 1'b1);
    assign w_wr_en  = io_ldr.i_rx_valid && (r_state == StDataHi);

`ifdef BIP_LOADER_CHECKSUM_EN
    logic [NB_BYTE-1:0] r_chk;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_chk <= '0;
        end else if (io_ldr.i_rx_valid) begin
            case (r_state)
                StIdle:                               r_chk <= '0;
                StLenLo, StLenHi, StDataLo, StDataHi: r_chk <= r_chk ^ io_ldr.i_rx_data;
                default:                              ;
            endcase
        end
    end
`endif

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: only stream strobes move the FSM; DONE and ERROR hold until reset.
    always_comb begin
        w_state_next = r_state;
        if (io_ldr.i_rx_valid) begin
            case (r_state)
                StIdle: begin
                    if (io_ldr.i_rx_data == SYNC_BYTE) w_state_next = StLenLo;
                end
                StLenLo: w_state_next = StLenHi;
                StLenHi: begin
                    if (w_len_rx == '0 || w_len_rx > NB_CNT'(N_INSMEM_ADDR)) begin
                        w_state_next = StError;
                    end else begin
                        w_state_next = StDataLo;
                    end
                end
                StDataLo: w_state_next = StDataHi;
                StDataHi: begin
                    if (w_last) begin
`ifdef BIP_LOADER_CHECKSUM_EN
                        w_state_next = StChk;
`else
                        w_state_next = StDone;
`endif
                    end else begin
                        w_state_next = StDataLo;
                    end
                end
`ifdef BIP_LOADER_CHECKSUM_EN
                StChk: begin
                    w_state_next = (io_ldr.i_rx_data == r_chk) ? StDone : StError;
                end
`endif
                default: ;
            endcase
        end
    end

    // Datapath: length, write pointer, low-byte holding register, fetch gate.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_len      <= '0;
            r_wr_ptr   <= '0;
            r_lo       <= '0;
            r_fetch_ok <= 1'b0;
        end else begin
            // Registered alongside the RAM read so the gate lines up with the read data.
            r_fetch_ok <= (r_state == StDone) && ({1'b0, io_ldr.i_addr_instr} < r_len);
            if (io_ldr.i_rx_valid) begin
                case (r_state)
                    StLenLo:  r_lo     <= io_ldr.i_rx_data;
                    StLenHi:  r_len    <= w_len_rx;
                    StDataLo: r_lo     <= io_ldr.i_rx_data;
                    StDataHi: r_wr_ptr <= r_wr_ptr + 1'b1;
                    default:  ;
                endcase
            end
        end
    end

    bip_insmem #(
        .NB_DATA            (NB_DATA),
        .N_INSMEM_ADDR      (N_INSMEM_ADDR),
        .LOG2_N_INSMEM_ADDR (LOG2_N_INSMEM_ADDR)
    ) u_insmem (
        .i_clock   (i_clock),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (LOG2_N_INSMEM_ADDR'(r_wr_ptr)),
        .i_wr_data ({io_ldr.i_rx_data, r_lo}),
        .i_rd_addr (io_ldr.i_addr_instr),
        .o_rd_data (w_rd_data)
    );

    // Outputs
    always_comb begin
        io_ldr.o_cpu_reset   = (r_state != StDone);
        io_ldr.o_load_done   = (r_state == StDone);
        io_ldr.o_load_error  = (r_state == StError);
        io_ldr.o_word_count  = r_wr_ptr;
        // Outside the loaded image, or before loading completes, fetches return HALT.
        io_ldr.o_instruction = r_fetch_ok ? w_rd_data : {OP_HALT, {(NB_DATA - 5){1'b0}}};
    end
endmodule

// File: tb/tb_bip_program_loader.sv
// Bench for bip_program_loader: table-driven frames, hand sequences for timing corners,
// and randomized frames checked against a byte-stream parsing model.
module tb_bip_program_loader;
    import bip_pkg::*;

    localparam int unsigned NB_DATA = 16;
    localparam int unsigned NB_BYTE = 8;
    localparam int unsigned N_WORDS = 2048;
    localparam int unsigned LOG2    = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bip_program_loader_if #(
        .NB_DATA            (NB_DATA),
        .NB_BYTE            (NB_BYTE),
        .LOG2_N_INSMEM_ADDR (LOG2)
    ) u_bus ();

    bip_program_loader #(
        .NB_DATA            (NB_DATA),
        .NB_BYTE            (NB_BYTE),
        .N_INSMEM_ADDR      (N_WORDS),
        .LOG2_N_INSMEM_ADDR (LOG2),
        .SYNC_BYTE          (8'hA5)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .io_ldr  (u_bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int g_max_gap = 0;

    // Model: bytes seen since the last reset, and the resulting image.
    logic [7:0]  q_bytes[$];
    logic [15:0] m_mem [N_WORDS];
    int          m_st;   // 0 idle/loading, 1 done, 2 error
    int          m_cnt;
    int          m_len;

    typedef struct {
        string       name;
        int          nb;
        logic [95:0] data;     // right-aligned, first byte most significant
        int          exp_done;
        int          exp_err;
        int          exp_cnt;
        bit          add_chk;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        u_bus.i_rx_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        q_bytes.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        u_bus.i_rx_data  = b;
        u_bus.i_rx_valid = 1'b1;
        q_bytes.push_back(b);
        tick();
        u_bus.i_rx_valid = 1'b0;
        u_bus.i_rx_data  = 8'h00;
        repeat ($urandom_range(0, g_max_gap)) tick();
    endtask

    // Interpret the byte stream as a whole: find the frame, decode length, collect words.
    task automatic model_eval();
        int i;
        int avail;
        int n;
        logic [7:0] x;
        m_st = 0; m_cnt = 0; m_len = 0;
        i = 0;
        while (i < q_bytes.size() && q_bytes[i] != 8'hA5) i++;
        if (i >= q_bytes.size()) return;
        i++;
        if (q_bytes.size() - i < 2) return;
        m_len = int'({q_bytes[i+1], q_bytes[i]}) % 4096;
        if (m_len == 0 || m_len > int'(N_WORDS)) begin
            m_st = 2;
            return;
        end
        avail = (q_bytes.size() - i - 2) / 2;
        m_cnt = (avail < m_len) ? avail : m_len;
        for (int k = 0; k < m_cnt; k++) m_mem[k] = {q_bytes[i+3+2*k], q_bytes[i+2+2*k]};
        if (m_cnt < m_len) return;
`ifdef BIP_LOADER_CHECKSUM_EN
        n = i + 2 + 2 * m_len;
        if (n >= q_bytes.size()) return;
        x = 8'h00;
        for (int k = i; k < n; k++) x = x ^ q_bytes[k];
        m_st = (x == q_bytes[n]) ? 1 : 2;
`else
        n = 0;
        x = 8'h00;
        m_st = 1 + int'(x) + n;
`endif
    endtask

    task automatic check_status(input string name);
        model_eval();
        check({name, "/cpu_reset"}, 32'(u_bus.o_cpu_reset), 32'(m_st != 1));
        check({name, "/done"},      32'(u_bus.o_load_done), 32'(m_st == 1));
        check({name, "/error"},     32'(u_bus.o_load_error), 32'(m_st == 2));
        check({name, "/count"},     32'(u_bus.o_word_count), 32'(m_cnt));
    endtask

    task automatic fetch(input string name, input int addr, input logic [15:0] exp);
        u_bus.i_addr_instr = LOG2'(addr);
        tick();
        check(name, 32'(u_bus.o_instruction), 32'(exp));
    endtask

    task automatic fetch_model(input string name, input int addr);
        fetch(name, addr, (m_st == 1 && addr < m_len) ? m_mem[addr] : 16'h0000);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] x;
        logic [7:0] lo;
        logic [7:0] hi;
        bit seen;
        int unsigned r;
        int len;
        int nd;

        u_bus.i_rx_data    = 8'h00;
        u_bus.i_rx_valid   = 1'b0;
        u_bus.i_addr_instr = '0;

        vecs.push_back('{"three_words", 9,
            96'({8'hA5, 8'h03, 8'h00, 8'h01, 8'h18, 8'h02, 8'h28, 8'h00, 8'h00}), 1, 0, 3, 1'b1});
        vecs.push_back('{"len_zero", 3, 96'({8'hA5, 8'h00, 8'h00}), 0, 1, 0, 1'b0});
        vecs.push_back('{"len_2049", 3, 96'({8'hA5, 8'h01, 8'h08}), 0, 1, 0, 1'b0});
        vecs.push_back('{"garbage_first", 7,
            96'({8'h11, 8'h22, 8'hA5, 8'h01, 8'h00, 8'h34, 8'h12}), 1, 0, 1, 1'b1});
        vecs.push_back('{"len_2048_ok", 3, 96'({8'hA5, 8'h00, 8'h08}), 0, 0, 0, 1'b0});
        vecs.push_back('{"len_high_bits", 7,
            96'({8'hA5, 8'h02, 8'hF0, 8'hAA, 8'hBB, 8'hCC, 8'hDD}), 1, 0, 2, 1'b1});
        vecs.push_back('{"partial", 5, 96'({8'hA5, 8'h02, 8'h00, 8'h34, 8'h12}), 0, 0, 1, 1'b0});

        // Reset state
        do_reset();
        check("reset/cpu_reset", 32'(u_bus.o_cpu_reset), 32'd1);
        check("reset/done", 32'(u_bus.o_load_done), 32'd0);
        check("reset/error", 32'(u_bus.o_load_error), 32'd0);
        check("reset/count", 32'(u_bus.o_word_count), 32'd0);
        check("reset/instr", 32'(u_bus.o_instruction), 32'd0);

        // Table-driven frames
        foreach (vecs[v]) begin
            do_reset();
            g_max_gap = int'($urandom_range(0, 5));
            seen = 1'b0;
            x = 8'h00;
            for (int k = 0; k < vecs[v].nb; k++) begin
                b = vecs[v].data[8*(vecs[v].nb-1-k) +: 8];
                if (seen) x = x ^ b;
                if (b == 8'hA5) seen = 1'b1;
                send_byte(b);
            end
`ifdef BIP_LOADER_CHECKSUM_EN
            if (vecs[v].add_chk) send_byte(x);
`endif
            check({vecs[v].name, "/done"}, 32'(u_bus.o_load_done), 32'(vecs[v].exp_done));
            check({vecs[v].name, "/error"}, 32'(u_bus.o_load_error), 32'(vecs[v].exp_err));
            check({vecs[v].name, "/cpu_reset"}, 32'(u_bus.o_cpu_reset),
                  32'(vecs[v].exp_done == 0));
            check({vecs[v].name, "/count"}, 32'(u_bus.o_word_count), 32'(vecs[v].exp_cnt));
        end
        g_max_gap = 0;

        // Fetch before the image completes returns HALT
        do_reset();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00); send_byte(8'h01); send_byte(8'h18);
        fetch("preload_fetch0", 0, 16'h0000);
        send_byte(8'h02); send_byte(8'h28); send_byte(8'h00);
        // Final byte: release of CPU reset happens only after the write commits
`ifdef BIP_LOADER_CHECKSUM_EN
        send_byte(8'h00);
        b = 8'h03 ^ 8'h00 ^ 8'h01 ^ 8'h18 ^ 8'h02 ^ 8'h28;
`else
        b = 8'h00;
`endif
        u_bus.i_rx_data  = b;
        u_bus.i_rx_valid = 1'b1;
        q_bytes.push_back(b);
        #1;
        check("final_byte/cpu_reset_before", 32'(u_bus.o_cpu_reset), 32'd1);
        tick();
        u_bus.i_rx_valid = 1'b0;
        check("final_byte/cpu_reset_after", 32'(u_bus.o_cpu_reset), 32'd0);
        check_status("frame1");
        // One-cycle fetch latency
        fetch("fetch0", 0, 16'h1801);
        u_bus.i_addr_instr = LOG2'(1);
        #1;
        check("fetch_latency_hold", 32'(u_bus.o_instruction), 32'h1801);
        tick();
        check("fetch1", 32'(u_bus.o_instruction), 32'h2802);
        fetch("fetch2", 2, 16'h0000);
        fetch("fetch_out_of_image3", 3, 16'h0000);
        fetch("fetch2047", 2047, 16'h0000);
        // DONE ignores further bytes
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'hEF); send_byte(8'hBE);
        check("done_ignores/count", 32'(u_bus.o_word_count), 32'd3);
        check("done_ignores/done", 32'(u_bus.o_load_done), 32'd1);
        fetch("done_ignores/fetch0", 0, 16'h1801);

        // Error is sticky until reset
        do_reset();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h34); send_byte(8'h12);
        check("err_sticky/error", 32'(u_bus.o_load_error), 32'd1);
        check("err_sticky/cpu_reset", 32'(u_bus.o_cpu_reset), 32'd1);
        do_reset();
        check("err_cleared/error", 32'(u_bus.o_load_error), 32'd0);

        // Reset mid-frame after the low byte of word 2, then a fresh frame
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h18); send_byte(8'h02);
        do_reset();
        check_status("midframe_reset");
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h78); send_byte(8'h56);
`ifdef BIP_LOADER_CHECKSUM_EN
        send_byte(8'h01 ^ 8'h78 ^ 8'h56);
`endif
        check_status("fresh_frame");
        fetch("fresh_frame/fetch0", 0, 16'h5678);
        fetch("fresh_frame/fetch1", 1, 16'h0000);

`ifdef BIP_LOADER_CHECKSUM_EN
        do_reset();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h34); send_byte(8'h12);
        check("chk_pending/done", 32'(u_bus.o_load_done), 32'd0);
        send_byte(8'h27);
        check("chk_good/done", 32'(u_bus.o_load_done), 32'd1);
        do_reset();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h28);
        check("chk_bad/error", 32'(u_bus.o_load_error), 32'd1);
        check("chk_bad/done", 32'(u_bus.o_load_done), 32'd0);
`endif

        // Randomized frames against the model
        for (int it = 0; it < 40; it++) begin
            do_reset();
            g_max_gap = int'($urandom_range(0, 5));
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                send_byte(b);
            end
            r = $urandom_range(0, 9);
            if (r == 0) begin
                lo = 8'h00;
                hi = {4'($urandom_range(0, 15)), 4'h0};
                len = 0;
            end else if (r == 1) begin
                lo = 8'($urandom_range(1, 255));
                hi = {4'($urandom_range(0, 15)), 4'(8 + $urandom_range(0, 7))};
                len = 0;
            end else begin
                len = int'($urandom_range(1, 6));
                lo = 8'(len);
                hi = {4'($urandom_range(0, 15)), 4'h0};
            end
            send_byte(8'hA5);
            send_byte(lo);
            send_byte(hi);
            x = lo ^ hi;
            nd = (len == 0) ? int'($urandom_range(0, 4)) : 2 * len;
            if (len != 0 && $urandom_range(0, 4) == 0) nd = int'($urandom_range(0, 2 * len - 1));
            for (int k = 0; k < nd; k++) begin
                b = 8'($urandom_range(0, 255));
                x = x ^ b;
                send_byte(b);
            end
`ifdef BIP_LOADER_CHECKSUM_EN
            if (len != 0 && nd == 2 * len) begin
                if ($urandom_range(0, 3) == 0) x = x ^ 8'h01;
                send_byte(x);
            end
`endif
            if (nd == 2 * len) begin
                repeat ($urandom_range(0, 2)) send_byte(8'($urandom_range(0, 255)));
            end
            check_status($sformatf("rand%0d", it));
            if (m_st == 1) begin
                for (int k = 0; k < 3; k++) begin
                    fetch_model($sformatf("rand%0d/fetch_in", it),
                                int'($urandom_range(0, m_len - 1)));
                end
                fetch_model($sformatf("rand%0d/fetch_out", it),
                            int'($urandom_range(m_len, N_WORDS - 1)));
            end else begin
                fetch_model($sformatf("rand%0d/fetch_notdone", it), 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
